mlp_sequencer: RTL and testbench

Initiator-side controller for the MLP inference core. It accepts one feature vector at a time over a valid/ready input channel and holds it stable on the core's `x` inputs. It issues a one-cycle `start`, waits for `done` under a watchdog, captures the class scores and performs a sequential signed argmax. The predicted class and scores are then presented on a valid/ready result channel, so the MLP core can be driven from a sample stream instead of raw start/done strobes.

---
 rtl/mlp_pkg.sv | 25 ++
 rtl/mlp_sequencer_if.sv | 37 +++
 rtl/mlp_argmax.sv | 42 ++++
 rtl/mlp_sequencer.sv | 117 +++++++++++
 tb/tb_mlp_sequencer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_pkg.sv
// Shared types and default sizes for the MLP core and its sequencer.
package mlp_pkg;

  localparam int unsigned FP_TOTAL_BITS      = 16;
  localparam int unsigned FP_FRAC_BITS       = 8;
  localparam int unsigned DEF_NUM_FEATURES   = 4;
  localparam int unsigned DEF_NUM_CLASSES    = 3;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

  typedef logic signed [FP_TOTAL_BITS-1:0] fp_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_ARGMAX,
    S_OUT
  } seq_state_e;

  // Index width that stays at least one bit wide for a single class.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mlp_sequencer_if.sv
// Sample, core and result channels of the MLP sequencer.
interface mlp_sequencer_if
  import mlp_pkg::*;
#(
  parameter int unsigned NUM_FEATURES = DEF_NUM_FEATURES,
  parameter int unsigned NUM_CLASSES  = DEF_NUM_CLASSES
);
  localparam int unsigned CLS_W = idx_width(NUM_CLASSES);

  logic                        in_valid;
  logic                        in_ready;
  fp_t  [NUM_FEATURES-1:0]     in_x;
  fp_t  [NUM_FEATURES-1:0]     mlp_x;
  logic                        mlp_start;
  logic                        mlp_done;
  fp_t  [NUM_CLASSES-1:0]      mlp_out;
  logic                        res_valid;
  logic                        res_ready;
  logic [CLS_W-1:0]            res_class;
  fp_t                         res_score;
  fp_t  [NUM_CLASSES-1:0]      res_scores;
  logic                        busy;
  logic                        timeout;

  modport master (
    input  in_valid, in_x, mlp_done, mlp_out, res_ready,
    output in_ready, mlp_x, mlp_start, res_valid, res_class, res_score,
           res_scores, busy, timeout
  );

  modport slave (
    output in_valid, in_x, mlp_done, mlp_out, res_ready,
    input  in_ready, mlp_x, mlp_start, res_valid, res_class, res_score,
           res_scores, busy, timeout
  );

endinterface

// File: rtl/mlp_argmax.sv
// Sequential signed argmax: one score per step, ties keep the lowest index.
module mlp_argmax
  import mlp_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = DEF_NUM_CLASSES,
  localparam int unsigned CLS_W      = idx_width(NUM_CLASSES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  fp_t                    first,
  input  logic                   step,
  input  fp_t [NUM_CLASSES-1:0]  scores,
  output logic                   done_c,
  output logic [CLS_W-1:0]       idx,
  output fp_t                    best
);

  logic [CLS_W-1:0] cnt_q;

  // High while the final index is being examined.
  assign done_c = (cnt_q == CLS_W'(NUM_CLASSES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx   <= '0;
      best  <= '0;
    end else if (load) begin
      cnt_q <= CLS_W'(1);
      idx   <= '0;
      best  <= first;
    end else if (step) begin
      if ($signed(scores[cnt_q]) > $signed(best)) begin
        best <= scores[cnt_q];
        idx  <= cnt_q;
      end
      cnt_q <= cnt_q + CLS_W'(1);
    end
  end

endmodule

// File: rtl/mlp_sequencer.sv
// Drives the MLP core from a sample stream: capture, start, watchdog wait,
// argmax over the returned scores and a valid/ready result channel.
module mlp_sequencer
  import mlp_pkg::*;
#(
  parameter int unsigned NUM_FEATURES   = DEF_NUM_FEATURES,
  parameter int unsigned NUM_CLASSES    = DEF_NUM_CLASSES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic              clk,
  input logic              reset,
  mlp_sequencer_if.master  bus
);

  localparam int unsigned CLS_W = idx_width(NUM_CLASSES);
  localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  seq_state_e              state_q, state_d;
  logic [WD_W-1:0]         wd_q;
  fp_t [NUM_FEATURES-1:0]  x_q;
  fp_t [NUM_CLASSES-1:0]   scores_q;
  logic                    in_ready_q, start_q, res_valid_q, busy_q, timeout_q;
  logic                    capture_x, capture_scores, ag_step, set_timeout;
  logic                    ag_done_c;
  logic [CLS_W-1:0]        ag_idx;
  fp_t                     ag_best;

  always_comb begin
    state_d        = state_q;
    capture_x      = 1'b0;
    capture_scores = 1'b0;
    ag_step        = 1'b0;
    set_timeout    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          capture_x = 1'b1;
          state_d   = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        // A done arriving in the last watchdog cycle still wins.
        if (bus.mlp_done) begin
          capture_scores = 1'b1;
          state_d        = (NUM_CLASSES > 1) ? S_ARGMAX : S_OUT;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          set_timeout = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_ARGMAX: begin
        ag_step = 1'b1;
        if (ag_done_c) state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State plus handshake/status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == S_IDLE);
      start_q     <= (state_d == S_START);
      res_valid_q <= (state_d == S_OUT);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q      <= '0;
      x_q       <= '0;
      scores_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (capture_x) x_q <= bus.in_x;
      if (state_q == S_START)     wd_q <= '0;
      else if (state_q == S_WAIT) wd_q <= wd_q + WD_W'(1);
      if (capture_scores) scores_q <= bus.mlp_out;
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

  mlp_argmax #(.NUM_CLASSES(NUM_CLASSES)) u_argmax (
    .clk    (clk),
    .reset  (reset),
    .load   (capture_scores),
    .first  (bus.mlp_out[0]),
    .step   (ag_step),
    .scores (scores_q),
    .done_c (ag_done_c),
    .idx    (ag_idx),
    .best   (ag_best)
  );

  assign bus.in_ready   = in_ready_q;
  assign bus.mlp_x      = x_q;
  assign bus.mlp_start  = start_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_class  = ag_idx;
  assign bus.res_score  = ag_best;
  assign bus.res_scores = scores_q;
  assign bus.busy       = busy_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_mlp_sequencer.sv
// Directed and randomized bench for mlp_sequencer with an argmax/latency model.
module tb_mlp_sequencer;
  import mlp_pkg::*;

  localparam int unsigned NF = 4;
  localparam int unsigned NC = 3;
  localparam int unsigned TO = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mlp_sequencer_if #(.NUM_FEATURES(NF), .NUM_CLASSES(NC)) bus ();

  mlp_sequencer #(
    .NUM_FEATURES  (NF),
    .NUM_CLASSES   (NC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  int checks = 0;
  int errors = 0;
  int exp_cls;
  int exp_val;
  logic exp_timeout = 1'b0;
  fp_t xs [NF];
  fp_t ss [NC];

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: maximum value first, then the lowest index holding it.
  function automatic void ref_argmax(input fp_t s [NC], output int cls, output int val);
    int mx;
    mx = int'(s[0]);
    foreach (s[i]) if (int'(s[i]) > mx) mx = int'(s[i]);
    cls = 0;
    for (int i = NC - 1; i >= 0; i--) if (int'(s[i]) == mx) cls = i;
    val = mx;
  endfunction

  task automatic scramble_core();
    for (int i = 0; i < NC; i++) bus.mlp_out[i] = fp_t'(16'($urandom));
  endtask

  // Handshake one vector; returns at the start of the first WAIT cycle.
  task automatic send_vec(input fp_t x [NF]);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < NF; i++) bus.in_x[i] = x[i];
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < NF; i++) bus.in_x[i] = fp_t'(16'($urandom));
    chk("start_pulse", bus.mlp_start, 1);
    chk("in_ready_busy", bus.in_ready, 0);
    chk("busy_start", bus.busy, 1);
    tick();
    chk("start_single", bus.mlp_start, 0);
    for (int i = 0; i < NF; i++) chk("mlp_x_hold", bus.mlp_x[i], x[i]);
  endtask

  // Present done in WAIT cycle k (1-based) and measure done-to-valid latency.
  task automatic finish_done(input int k, input fp_t s [NC]);
    int n;
    repeat (k - 1) tick();
    bus.mlp_done = 1'b1;
    for (int i = 0; i < NC; i++) bus.mlp_out[i] = s[i];
    tick();
    bus.mlp_done = 1'b0;
    scramble_core();
    n = 0;
    while (!bus.res_valid && n < 20) begin
      tick();
      n++;
    end
    chk("done_to_valid", n, NC - 1);
  endtask

  task automatic check_result(input fp_t s [NC]);
    ref_argmax(s, exp_cls, exp_val);
    chk("res_valid", bus.res_valid, 1);
    chk("res_class", bus.res_class, exp_cls);
    chk("res_score", bus.res_score, exp_val);
    for (int i = 0; i < NC; i++) chk("res_scores", bus.res_scores[i], s[i]);
    chk("timeout_flag", bus.timeout, exp_timeout);
  endtask

  task automatic release_result();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("res_valid_drop", bus.res_valid, 0);
    chk("in_ready_back", bus.in_ready, 1);
    chk("busy_clear", bus.busy, 0);
    chk("res_class_kept", bus.res_class, exp_cls);
  endtask

  initial begin
    logic saw_valid;
    int k;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.mlp_done  = 1'b0;
    bus.mlp_out   = '0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_start", bus.mlp_start, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_res_score", bus.res_score, 0);

    // Basic: done 5 cycles after start.
    xs = '{fp_t'(256), fp_t'(0), fp_t'(0), fp_t'(0)};
    ss = '{fp_t'(100), fp_t'(-50), fp_t'(300)};
    send_vec(xs);
    finish_done(5, ss);
    check_result(ss);
    release_result();

    // Tie resolves to the lowest index.
    xs = '{fp_t'(1), fp_t'(2), fp_t'(3), fp_t'(4)};
    ss = '{fp_t'(200), fp_t'(200), fp_t'(-1)};
    send_vec(xs);
    finish_done(2, ss);
    check_result(ss);
    release_result();

    // All negative scores need a signed compare.
    ss = '{fp_t'(-300), fp_t'(-10), fp_t'(-200)};
    send_vec(xs);
    finish_done(1, ss);
    check_result(ss);
    release_result();

    // Backpressure with a new vector already offered.
    xs = '{fp_t'(-7), fp_t'(9), fp_t'(11), fp_t'(-13)};
    ss = '{fp_t'(5), fp_t'(-6), fp_t'(7)};
    send_vec(xs);
    finish_done(3, ss);
    check_result(ss);
    bus.in_valid = 1'b1;
    for (int i = 0; i < NF; i++) bus.in_x[i] = fp_t'(1000 + i);
    repeat (10) begin
      tick();
      chk("bp_valid", bus.res_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_class", bus.res_class, exp_cls);
      chk("bp_score", bus.res_score, exp_val);
      chk("bp_no_capture", bus.mlp_x[0], xs[0]);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("bp_release_idle", bus.in_ready, 1);
    chk("bp_release_nostart", bus.mlp_start, 0);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_next_start", bus.mlp_start, 1);
    chk("bp_next_capture", bus.mlp_x[0], 1000);
    tick();
    ss = '{fp_t'(0), fp_t'(3), fp_t'(3)};
    finish_done(4, ss);
    check_result(ss);
    release_result();

    // Randomized samples, including done in the final watchdog cycle.
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < NF; i++) xs[i] = fp_t'(16'($urandom));
      for (int i = 0; i < NC; i++) ss[i] = fp_t'(16'($urandom));
      if (it % 4 == 1) ss[2] = ss[0];
      if (it % 4 == 2) ss[1] = ss[2];
      k = (it == 0) ? int'(TO) : int'($urandom_range(1, TO));
      send_vec(xs);
      finish_done(k, ss);
      check_result(ss);
      repeat ($urandom_range(0, 3)) begin
        tick();
        chk("rnd_hold_valid", bus.res_valid, 1);
      end
      release_result();
    end

    // Timeout: no done ever arrives.
    send_vec(xs);
    saw_valid = 1'b0;
    repeat (TO - 1) begin
      tick();
      saw_valid = saw_valid | bus.res_valid;
    end
    chk("to_not_yet", bus.timeout, 0);
    chk("to_still_busy", bus.busy, 1);
    tick();
    exp_timeout = 1'b1;
    chk("to_set", bus.timeout, 1);
    chk("to_idle", bus.in_ready, 1);
    chk("to_no_result", saw_valid | bus.res_valid, 0);

    // Normal sample after timeout; flag stays set.
    ss = '{fp_t'(-1), fp_t'(-2), fp_t'(4)};
    send_vec(xs);
    finish_done(6, ss);
    check_result(ss);
    release_result();

    // Reset mid-WAIT, then a late done that must be ignored.
    send_vec(xs);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_timeout = 1'b0;
    chk("mr_in_ready", bus.in_ready, 1);
    chk("mr_start", bus.mlp_start, 0);
    chk("mr_res_valid", bus.res_valid, 0);
    chk("mr_busy", bus.busy, 0);
    chk("mr_timeout", bus.timeout, 0);
    chk("mr_class", bus.res_class, 0);
    chk("mr_score", bus.res_score, 0);
    for (int i = 0; i < NF; i++) chk("mr_mlp_x", bus.mlp_x[i], 0);
    for (int i = 0; i < NC; i++) chk("mr_scores", bus.res_scores[i], 0);
    bus.mlp_done = 1'b1;
    for (int i = 0; i < NC; i++) bus.mlp_out[i] = fp_t'(77 + i);
    tick();
    bus.mlp_done = 1'b0;
    repeat (5) begin
      tick();
      chk("late_done_valid", bus.res_valid, 0);
      chk("late_done_busy", bus.busy, 0);
    end
    chk("late_done_scores", bus.res_scores[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
